// File: rtl/spi_master_write.sv
// Write-only SPI initiator: one {addr,data} request becomes a CS/SCLK/SDATA frame plus commit pulses.
// Request-to-CS latency 1 cycle; REQ is only looked at while idle, so a busy link simply ignores it.
module spi_master_write #(
  parameter int DIV       = 2,
  parameter int POST_CLKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic       cs_o,
  output logic       sclk_o,
  output logic       sdata_o
);

  localparam int            CW          = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(DIV - 1);
  localparam logic [4:0]    DATA_PULSES = 5'd16;
  localparam logic [4:0]    ALL_PULSES  = 5'(16 + POST_CLKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_TAIL,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] half_q, half_d;
  logic [4:0]    pulse_q, pulse_d;
  logic [15:0]   sr_q;
  logic          ack_q, busy_q, cs_q, sclk_q;
  logic          half_end;

  always_comb begin
    half_end = (half_q == HALF_LAST);
    half_d   = (state_q == S_IDLE || half_end) ? '0 : half_q + 1'b1;
    pulse_d  = pulse_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      pulse_q <= '0;
      sr_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      half_q <= half_d;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            state_q <= S_SHIFT;
            sr_q    <= {addr_i, data_i};
            pulse_q <= '0;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            cs_q    <= 1'b1;
          end
        end
        // The shifter drains to zero after 16 falls, so tail pulses carry SDATA=0 for free.
        S_SHIFT, S_TAIL: begin
          if (half_end) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q  <= 1'b0;
              sr_q    <= {sr_q[14:0], 1'b0};
              pulse_q <= pulse_d;
              if (pulse_d == ALL_PULSES) begin
                state_q <= S_HOLD;
              end else if (pulse_d == DATA_PULSES) begin
                state_q <= S_TAIL;
              end
            end
          end
        end
        S_HOLD: begin
          if (half_end) begin
            cs_q    <= 1'b0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (half_end) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sr_q[15];

endmodule

// File: tb/tb_spi_master_write.sv
// Bench for spi_master_write: three parameter sets, vector table, corner sequences, random traffic.
module tb_spi_master_write;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [3];
  logic       req   [3];
  logic [7:0] addr  [3];
  logic [7:0] data  [3];
  logic       ack   [3];
  logic       busy  [3];
  logic       cs    [3];
  logic       sclk  [3];
  logic       sdata [3];

  spi_master_write #(.DIV(2), .POST_CLKS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n[0]), .req_i(req[0]), .addr_i(addr[0]), .data_i(data[0]),
    .ack_o(ack[0]), .busy_o(busy[0]), .cs_o(cs[0]), .sclk_o(sclk[0]), .sdata_o(sdata[0]));
  spi_master_write #(.DIV(1), .POST_CLKS(0)) u_d1 (
    .clk(clk), .rst_n(rst_n[1]), .req_i(req[1]), .addr_i(addr[1]), .data_i(data[1]),
    .ack_o(ack[1]), .busy_o(busy[1]), .cs_o(cs[1]), .sclk_o(sclk[1]), .sdata_o(sdata[1]));
  spi_master_write #(.DIV(5), .POST_CLKS(3)) u_d2 (
    .clk(clk), .rst_n(rst_n[2]), .req_i(req[2]), .addr_i(addr[2]), .data_i(data[2]),
    .ack_o(ack[2]), .busy_o(busy[2]), .cs_o(cs[2]), .sclk_o(sclk[2]), .sdata_o(sdata[2]));

  int checks   = 0;
  int failures = 0;

  function automatic int dv(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 5;
  endfunction
  function automatic int pc(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction
  function automatic int blen(input int i);
    return (16 + pc(i)) * 2 * dv(i) + 2 * dv(i);
  endfunction

  // Reference: a frame is a start cycle plus the captured word; outputs follow from arithmetic on the offset.
  int          cyc = 0;
  bit          act   [3];
  int          start [3];
  logic [15:0] frame [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        act[i] <= 1'b0;
      end else if (req[i] && (!act[i] || (cyc - start[i]) >= blen(i))) begin
        act[i]   <= 1'b1;
        start[i] <= cyc + 1;
        frame[i] <= {addr[i], data[i]};
      end
    end
    cyc <= cyc + 1;
  end

  function automatic logic [4:0] exp_out(input int i);
    int d, c, nclk;
    logic [4:0] r;
    r    = '0;
    d    = dv(i);
    c    = cyc - start[i];
    nclk = (16 + pc(i)) * 2 * d;
    if (rst_n[i] && act[i] && c >= 0 && c < nclk + 2 * d) begin
      r[4] = (c == 0);
      r[3] = 1'b1;
      r[2] = (c < nclk + d);
      r[1] = (c < nclk) && (((c / d) % 2) == 1);
      r[0] = (c < 32 * d) ? frame[i][15 - c / (2 * d)] : 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic monitor();
    logic [4:0] pv [3];
    logic       pr [3];
    logic [4:0] g;
    for (int i = 0; i < 3; i++) begin
      pv[i] = '0;
      pr[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        g = {ack[i], busy[i], cs[i], sclk[i], sdata[i]};
        chk($sformatf("outs_cfg%0d_cyc%0d", i, cyc), int'(g), int'(exp_out(i)));
        if (rst_n[i] && pr[i] && g[0] != pv[i][0])
          chk($sformatf("sdata_move_cfg%0d_cyc%0d", i, cyc),
              int'((pv[i][1] && !g[1]) || (!pv[i][2] && g[2])), 1);
        pv[i] = g;
        pr[i] = rst_n[i];
      end
    end
  endtask

  task automatic run_vec(input int i, input logic [7:0] a, input logic [7:0] d,
                         output logic [15:0] word, output int pulses, output int cslen,
                         output int busylen, output int acklen, output int acklat,
                         output int rise1, output int tail1);
    logic ps;
    ps = 1'b0; word = '0; pulses = 0; cslen = 0; busylen = 0;
    acklen = 0; acklat = -1; rise1 = -1; tail1 = 0;
    @(posedge clk);
    #2;
    addr[i] = a; data[i] = d; req[i] = 1'b1;
    @(posedge clk);
    #2;
    req[i] = 1'b0;
    for (int n = 1; n <= 260; n++) begin
      @(negedge clk);
      if (ack[i]) begin
        acklen++;
        if (acklat < 0) acklat = n;
      end
      busylen += int'(busy[i]);
      cslen   += int'(cs[i]);
      if (sclk[i] && !ps) begin
        pulses++;
        if (rise1 < 0) rise1 = n;
        if (pulses <= 16) word = {word[14:0], sdata[i]};
        else tail1 += int'(sdata[i]);
      end
      ps = sclk[i];
      addr[i] = 8'($urandom);
      data[i] = 8'($urandom);
    end
  endtask

  typedef struct {
    int          cfg;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] word;
    int          pulses;
    int          cslen;
    int          busylen;
    int          rise1;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [15:0] w;
    int          np, ncs, nbusy, nack, lat, r1, t1, nb, sp;
    logic        ps, pcs;
    int          ackq [$];
    logic [15:0] wq [$];

    vecs[0] = '{0, 8'h01, 8'hA5, 16'h01A5, 17, 70, 72, 3};
    vecs[1] = '{0, 8'h80, 8'h01, 16'h8001, 17, 70, 72, 3};
    vecs[2] = '{1, 8'h5A, 8'h0F, 16'h5A0F, 16, 33, 34, 2};
    vecs[3] = '{1, 8'hFF, 8'hFF, 16'hFFFF, 16, 33, 34, 2};
    vecs[4] = '{2, 8'h3C, 8'h96, 16'h3C96, 19, 195, 200, 6};
    vecs[5] = '{2, 8'h00, 8'h00, 16'h0000, 19, 195, 200, 6};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      req[i]   = 1'b1;
      addr[i]  = 8'($urandom);
      data[i]  = 8'($urandom);
    end
    fork
      monitor();
    join_none

    // Held in reset with REQ high: everything stays quiet.
    tick(4);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outs_cfg%0d", i),
          int'({ack[i], busy[i], cs[i], sclk[i], sdata[i]}), 0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    req[1] = 1'b0;
    req[2] = 1'b0;
    @(negedge clk);
    chk("ack_before_first_edge", int'(ack[0]), 0);
    @(posedge clk);
    #2;
    req[0] = 1'b0;
    @(negedge clk);
    chk("ack_first_edge", int'({ack[0], busy[0], cs[0]}), 7);
    tick(80);

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v].cfg, vecs[v].a, vecs[v].d, w, np, ncs, nbusy, nack, lat, r1, t1);
      chk($sformatf("vec%0d_word", v), int'(w), int'(vecs[v].word));
      chk($sformatf("vec%0d_pulses", v), np, vecs[v].pulses);
      chk($sformatf("vec%0d_cs_len", v), ncs, vecs[v].cslen);
      chk($sformatf("vec%0d_busy_len", v), nbusy, vecs[v].busylen);
      chk($sformatf("vec%0d_ack_len", v), nack, 1);
      chk($sformatf("vec%0d_ack_lat", v), lat, 1);
      chk($sformatf("vec%0d_first_rise", v), r1, vecs[v].rise1);
      chk($sformatf("vec%0d_tail_ones", v), t1, 0);
    end

    // REQ held high; inputs move at cycle 10 and must not disturb the first frame.
    @(posedge clk);
    #2;
    addr[0] = 8'h00; data[0] = 8'h3C; req[0] = 1'b1;
    ps = 1'b0; pcs = 1'b0; nb = 0; w = '0;
    for (int n = 1; n <= 150; n++) begin
      @(posedge clk);
      #2;
      if (n == 10) begin
        addr[0] = 8'h01;
        data[0] = 8'hC3;
      end
      @(negedge clk);
      if (ack[0]) ackq.push_back(n);
      if (cs[0] && !pcs) begin
        w  = '0;
        nb = 0;
      end
      if (sclk[0] && !ps && nb < 16) begin
        w = {w[14:0], sdata[0]};
        nb++;
      end
      if (!cs[0] && pcs) wq.push_back(w);
      ps  = sclk[0];
      pcs = cs[0];
    end
    req[0] = 1'b0;
    chk("b2b_ack_count", ackq.size(), 3);
    sp = (ackq.size() >= 2) ? ackq[1] - ackq[0] : -1;
    chk("b2b_ack_spacing", sp, 73);
    chk("b2b_frame_count", wq.size(), 2);
    chk("b2b_word0", (wq.size() >= 1) ? int'(wq[0]) : -1, 16'h003C);
    chk("b2b_word1", (wq.size() >= 2) ? int'(wq[1]) : -1, 16'h01C3);
    tick(220);

    // Asynchronous reset 30 cycles into a frame, then a clean frame.
    addr[0] = 8'hE7; data[0] = 8'h18; req[0] = 1'b1;
    tick(1);
    req[0] = 1'b0;
    tick(29);
    chk("pre_reset_busy", int'({busy[0], cs[0]}), 3);
    rst_n[0] = 1'b0;
    req[0]   = 1'b1;
    #1;
    chk("mid_reset_outs", int'({ack[0], busy[0], cs[0], sclk[0], sdata[0]}), 0);
    tick(3);
    chk("reset_hold_no_ack", int'({ack[0], busy[0]}), 0);
    req[0]   = 1'b0;
    rst_n[0] = 1'b1;
    tick(2);
    run_vec(0, 8'h5A, 8'hC3, w, np, ncs, nbusy, nack, lat, r1, t1);
    chk("post_reset_word", int'(w), 16'h5AC3);
    chk("post_reset_pulses", np, 17);
    chk("post_reset_busy_len", nbusy, 72);
    chk("post_reset_cs_len", ncs, 70);

    // Random traffic with occasional resets, judged by the reference model each cycle.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 700; n++) begin
        @(posedge clk);
        #2;
        req[i]   = ($urandom_range(0, 3) != 0);
        addr[i]  = 8'($urandom);
        data[i]  = 8'($urandom);
        rst_n[i] = ($urandom_range(0, 299) != 0);
      end
      @(posedge clk);
      #2;
      rst_n[i] = 1'b1;
      req[i]   = 1'b0;
      tick(220);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_write.md
# spi_master_write

Initiator side of the team's single-direction SPI write link. It converts a parallel write request (8-bit address, 8-bit data) on the system clock into one serial frame on CS/SCLK/SDATA, which the SPI slave + register block in the device under test consumes. SCLK is derived from CLK by an integer divider. The block also issues the trailing SCLK pulse(s) the SCLK-clocked register file needs to commit the write.

## Interface
- DIV, 2: SCLK half-period in CLK cycles; legal 1..255.
- POST_CLKS, 1: extra SCLK pulses after bit 16 with CS still high and SDATA=0; legal 0..3.
- CLK  input  1  system clock; all state on rising edge.
- RSTX  input  1  asynchronous active-low reset.
- REQ  input  1  write request, level; sampled only in IDLE.
- ADDR  input  8  register address; captured with REQ.
- DATA  input  8  write data; captured with REQ.
- ACK  output  1  one-cycle pulse: request accepted.
- BUSY  output  1  high while a frame (including gap) is in progress.
- CS  output  1  chip select, active high, idle low.
- SCLK  output  1  serial clock, idle low.
- SDATA  output  1  serial data, MSB first; slave samples on SCLK rising edge.

## Operation
- Frame = 16 data bits: ADDR[7:0] then DATA[7:0], MSB first, followed by POST_CLKS pulses with SDATA=0.
- States: IDLE -> SHIFT -> TAIL -> HOLD -> GAP -> IDLE.
- IDLE: CS=0, SCLK=0, SDATA=0, BUSY=0. REQ=1 at a rising edge: capture {ADDR,DATA} into a 16-bit shift register, go SHIFT; next cycle ACK=1, BUSY=1, CS=1, SDATA=ADDR[7].
- SHIFT: each bit = DIV cycles SCLK low then DIV cycles SCLK high. SDATA changes only in the same cycle SCLK falls (and at CS rise for bit 15). After 16th high phase -> TAIL (or HOLD if POST_CLKS=0).
- TAIL: POST_CLKS pulses, same low/high shape, SDATA=0.
- HOLD: SCLK=0, CS=1 for DIV cycles after the last falling edge.
- GAP: CS=0, BUSY=1 for DIV cycles; then IDLE.
- Counters: half-period counter ceil(log2(DIV+1)) bits; pulse counter 5 bits (max 19 pulses).
- REQ while BUSY: ignored, no ACK; ADDR/DATA changes after capture have no effect.
- REQ held high continuously: frames issued back to back, separated only by GAP.
- All outputs registered; no combinational path from inputs to outputs.

## Timing
- Reset (RSTX=0, any time, async): CS=0, SCLK=0, SDATA=0, ACK=0, BUSY=0, state IDLE; mid-frame reset aborts frame immediately (CS drops, no further pulses). First REQ sampled at first CLK edge after RSTX rises.
- Request sampled at edge E (cycle t); ACK, BUSY, CS rise in cycle t+1; ACK high exactly one cycle.
- First SCLK rising edge at cycle t+1+DIV; pulse k (k=0..) rises at t+1+DIV+2*DIV*k.
- BUSY length = (16+POST_CLKS)*2*DIV + 2*DIV cycles; DIV=2, POST_CLKS=1: 72 cycles (t+1..t+72).
- CS high length = (16+POST_CLKS)*2*DIV + DIV cycles; 70 at defaults.
- Back-to-back ACK spacing = BUSY length + 1; 73 at defaults.
- DIV=1: SCLK = CLK/2, all rules above hold unchanged.

## Test plan
- Reset values: hold RSTX=0, toggle CLK, REQ=1 -> all outputs 0, no ACK until RSTX=1.
- Single write defaults: ADDR=0x01, DATA=0xA5 -> ACK 1 cycle, slave decodes 16 bits 0x01A5, 17 SCLK rising edges, CS high 70 cycles, BUSY 72 cycles; slave REG_01 = 0xA5.
- REQ held high with ADDR/DATA changed mid-frame (0x00/0x3C then 0x01/0xC3 at cycle 10) -> first frame carries 0x003C; second frame 0x01C3 with ACK 73 cycles after first.
- Parameters DIV=1, POST_CLKS=0 -> 16 SCLK pulses, period 2 CLK, BUSY 34 cycles; DIV=5, POST_CLKS=3 -> 19 pulses, BUSY 200 cycles.
- Async reset at cycle 30 of a frame -> CS/SCLK/SDATA/BUSY low in same cycle; next REQ yields full clean frame.
- SDATA stability check: at every SCLK rising edge SDATA unchanged since prior falling edge and for DIV cycles after; SDATA=0 in TAIL.
